// File: rtl/psm_wr_buffer.sv
// psm_wr_buffer: write-side data buffer for the partial-sum manager.
// It stores SRAM-word-wide partial-sum vectors from the array drain path in a FIFO.
// Each cycle it merges the head entry with the index counter's address and lane mask
// to form one registered, masked SRAM write. The counter's pop strobe retires the head.
//
// Ports:
//   i_clk, i_rst                clock; asynchronous active-high reset
//   i_clear                     synchronous flush of FIFO, write strobe and error flags
//   i_push, i_push_data         FIFO write side (lane 0 = bits [OC_W-1:0])
//   o_full, o_empty, o_count    FIFO occupancy status (registered)
//   i_cnt_en, i_mask,
//   i_sram_addr, i_pop          index-counter pipeline inputs
//   o_sram_wren/addr/wdata/
//   o_sram_wmask                registered SRAM write port
//   o_ovf_err, o_udf_err        sticky overflow and underflow flags
module psm_wr_buffer #(
    parameter int unsigned OC_W    = 16,
    parameter int unsigned SRAMC_N = 2,
    parameter int unsigned ADRC_W  = 8,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_clear,
    input  logic                         i_push,
    input  logic [SRAMC_N*OC_W-1:0]      i_push_data,
    output logic                         o_full,
    output logic                         o_empty,
    input  logic                         i_cnt_en,
    input  logic [SRAMC_N-1:0]           i_mask,
    input  logic [ADRC_W-1:0]            i_sram_addr,
    input  logic                         i_pop,
    output logic                         o_sram_wren,
    output logic [ADRC_W-1:0]            o_sram_addr,
    output logic [SRAMC_N*OC_W-1:0]      o_sram_wdata,
    output logic [SRAMC_N-1:0]           o_sram_wmask,
    output logic                         o_ovf_err,
    output logic                         o_udf_err,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned DATA_W = SRAMC_N * OC_W;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              pop_eff;
    logic              push_ok;
    logic              wr_req;
    logic              wr_go;
    logic              udf_evt;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] wdata_nxt;
    logic [CNT_W-1:0]  count_nxt;

    // Handshake decode. A full FIFO still accepts a push when the head retires in the same cycle.
    always_comb begin
        pop_eff = i_pop && i_cnt_en && !o_empty;
        push_ok = i_push && (!o_full || pop_eff);
        wr_req  = i_cnt_en && (|i_mask);
        wr_go   = wr_req && !o_empty;
        udf_evt = o_empty && ((i_pop && i_cnt_en) || wr_req);
        head    = mem[rd_ptr];
    end

    // Lane masking: a lane whose mask bit is clear is driven to zero.
    always_comb begin
        wdata_nxt = '0;
        for (int unsigned l = 0; l < SRAMC_N; l++) begin
            if (i_mask[l]) begin
                wdata_nxt[l*OC_W +: OC_W] = head[l*OC_W +: OC_W];
            end
        end
    end

    // Next occupancy
    always_comb begin
        count_nxt = o_count;
        case ({push_ok, pop_eff})
            2'b10:   count_nxt = o_count + CNT_W'(1);
            2'b01:   count_nxt = o_count - CNT_W'(1);
            default: count_nxt = o_count;
        endcase
    end

    // Storage array. It has no reset because its contents only matter once they are pushed.
    always_ff @(posedge i_clk) begin
        if (push_ok && !i_clear) begin
            mem[wr_ptr] <= i_push_data;
        end
    end

    // Pointers, status, error flags and the SRAM write register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_count      <= '0;
            o_empty      <= 1'b1;
            o_full       <= 1'b0;
            o_sram_wren  <= 1'b0;
            o_sram_addr  <= '0;
            o_sram_wdata <= '0;
            o_sram_wmask <= '0;
            o_ovf_err    <= 1'b0;
            o_udf_err    <= 1'b0;
        end else if (i_clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_count     <= '0;
            o_empty     <= 1'b1;
            o_full      <= 1'b0;
            o_sram_wren <= 1'b0;
            o_ovf_err   <= 1'b0;
            o_udf_err   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            o_count <= count_nxt;
            o_empty <= (count_nxt == '0);
            o_full  <= (count_nxt == CNT_W'(DEPTH));
            if (i_push && !push_ok) begin
                o_ovf_err <= 1'b1;
            end
            if (udf_evt) begin
                o_udf_err <= 1'b1;
            end
            // The write reads the head before any same-cycle retirement takes effect.
            o_sram_wren <= wr_go;
            if (wr_go) begin
                o_sram_addr  <= i_sram_addr;
                o_sram_wdata <= wdata_nxt;
                o_sram_wmask <= i_mask;
            end
        end
    end

endmodule

// File: tb/tb_psm_wr_buffer.sv
// tb_psm_wr_buffer: directed-vector bench for psm_wr_buffer.
// Inputs change 1 time unit after the rising edge. Outputs are checked at that same point,
// before the inputs change.
module tb_psm_wr_buffer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_clear;
    logic        i_push;
    logic [31:0] i_push_data;
    logic        o_full;
    logic        o_empty;
    logic        i_cnt_en;
    logic [1:0]  i_mask;
    logic [7:0]  i_sram_addr;
    logic        i_pop;
    logic        o_sram_wren;
    logic [7:0]  o_sram_addr;
    logic [31:0] o_sram_wdata;
    logic [1:0]  o_sram_wmask;
    logic        o_ovf_err;
    logic        o_udf_err;
    logic [2:0]  o_count;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] fw [6];
    logic [31:0] wv [10];

    psm_wr_buffer #(
        .OC_W(16), .SRAMC_N(2), .ADRC_W(8), .DEPTH(4)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_clear(i_clear),
        .i_push(i_push),
        .i_push_data(i_push_data),
        .o_full(o_full),
        .o_empty(o_empty),
        .i_cnt_en(i_cnt_en),
        .i_mask(i_mask),
        .i_sram_addr(i_sram_addr),
        .i_pop(i_pop),
        .o_sram_wren(o_sram_wren),
        .o_sram_addr(o_sram_addr),
        .o_sram_wdata(o_sram_wdata),
        .o_sram_wmask(o_sram_wmask),
        .o_ovf_err(o_ovf_err),
        .o_udf_err(o_udf_err),
        .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_push   = 1'b0;
        i_cnt_en = 1'b0;
        i_pop    = 1'b0;
        i_mask   = 2'b00;
        i_clear  = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        i_push_data = '0;
        i_sram_addr = '0;
        idle();
        for (int i = 0; i < 6; i++) fw[i] = 32'hF000_0000 | 32'(i * 32'h0011_0022 + 1);
        for (int k = 0; k < 10; k++) wv[k] = 32'hA000_0000 | 32'(k * 32'h0001_0003 + 5);

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_empty", 64'(o_empty), 64'(1));
        chk("rst_full",  64'(o_full),  64'(0));
        chk("rst_count", 64'(o_count), 64'(0));
        chk("rst_wren",  64'(o_sram_wren), 64'(0));
        chk("rst_addr",  64'(o_sram_addr), 64'(0));
        chk("rst_wdata", 64'(o_sram_wdata), 64'(0));
        chk("rst_wmask", 64'(o_sram_wmask), 64'(0));
        chk("rst_ovf",   64'(o_ovf_err), 64'(0));
        chk("rst_udf",   64'(o_udf_err), 64'(0));
        i_rst = 1'b0;
        step();

        // Basic full-word write with pop
        i_push = 1'b1; i_push_data = 32'hBBBB_AAAA;
        step();
        chk("basic_count1", 64'(o_count), 64'(1));
        chk("basic_nempty", 64'(o_empty), 64'(0));
        idle();
        i_cnt_en = 1'b1; i_mask = 2'b11; i_sram_addr = 8'h05; i_pop = 1'b1;
        step();
        chk("basic_wren",  64'(o_sram_wren), 64'(1));
        chk("basic_addr",  64'(o_sram_addr), 64'(8'h05));
        chk("basic_wdata", 64'(o_sram_wdata), 64'(32'hBBBB_AAAA));
        chk("basic_wmask", 64'(o_sram_wmask), 64'(2'b11));
        chk("basic_empty", 64'(o_empty), 64'(1));
        idle();
        step();
        chk("basic_wren0",    64'(o_sram_wren), 64'(0));
        chk("basic_addrhold", 64'(o_sram_addr), 64'(8'h05));

        // Partial-mask writes against one head entry
        i_push = 1'b1; i_push_data = 32'h2222_1111;
        step();
        idle();
        i_cnt_en = 1'b1; i_mask = 2'b01; i_sram_addr = 8'h07;
        step();
        chk("part1_wren",  64'(o_sram_wren), 64'(1));
        chk("part1_wdata", 64'(o_sram_wdata), 64'(32'h0000_1111));
        chk("part1_wmask", 64'(o_sram_wmask), 64'(2'b01));
        chk("part1_count", 64'(o_count), 64'(1));
        i_mask = 2'b10; i_sram_addr = 8'h08; i_pop = 1'b1;
        step();
        chk("part2_wdata", 64'(o_sram_wdata), 64'(32'h2222_0000));
        chk("part2_addr",  64'(o_sram_addr), 64'(8'h08));
        chk("part2_count", 64'(o_count), 64'(0));
        chk("part2_udf",   64'(o_udf_err), 64'(0));
        idle();

        // Full boundary
        for (int i = 0; i < 4; i++) begin
            i_push = 1'b1; i_push_data = fw[i];
            step();
        end
        chk("full_flag",  64'(o_full),  64'(1));
        chk("full_count", 64'(o_count), 64'(4));
        i_push_data = fw[4]; i_cnt_en = 1'b1; i_pop = 1'b1; i_mask = 2'b11; i_sram_addr = 8'h10;
        step();
        chk("fullpp_count", 64'(o_count), 64'(4));
        chk("fullpp_ovf",   64'(o_ovf_err), 64'(0));
        chk("fullpp_wdata", 64'(o_sram_wdata), 64'(fw[0]));
        idle();
        i_push = 1'b1; i_push_data = fw[5];
        step();
        chk("ovf_flag",  64'(o_ovf_err), 64'(1));
        chk("ovf_count", 64'(o_count), 64'(4));
        chk("ovf_wren",  64'(o_sram_wren), 64'(0));
        idle();
        for (int i = 0; i < 4; i++) begin
            i_cnt_en = 1'b1; i_pop = 1'b1; i_mask = 2'b11; i_sram_addr = 8'(8'h11 + i);
            step();
            chk($sformatf("drain%0d_wdata", i), 64'(o_sram_wdata), 64'(fw[i+1]));
            chk($sformatf("drain%0d_addr", i),  64'(o_sram_addr), 64'(8'h11 + i));
        end
        idle();
        chk("drain_empty", 64'(o_empty), 64'(1));
        chk("drain_ovf_sticky", 64'(o_ovf_err), 64'(1));
        i_clear = 1'b1;
        step();
        idle();
        chk("clr_ovf", 64'(o_ovf_err), 64'(0));

        // Wrap-around in 1:1 flow
        i_push = 1'b1; i_push_data = wv[0];
        step();
        for (int k = 1; k <= 10; k++) begin
            i_push = (k < 10);
            if (k < 10) i_push_data = wv[k];
            i_cnt_en = 1'b1; i_pop = 1'b1; i_mask = 2'b11; i_sram_addr = 8'(8'h40 + k);
            step();
            chk($sformatf("wrap%0d_wdata", k), 64'(o_sram_wdata), 64'(wv[k-1]));
            chk($sformatf("wrap%0d_addr", k),  64'(o_sram_addr), 64'(8'h40 + k));
        end
        idle();
        chk("wrap_empty", 64'(o_empty), 64'(1));
        chk("wrap_udf",   64'(o_udf_err), 64'(0));

        // Underflow then clear
        i_cnt_en = 1'b1; i_mask = 2'b11; i_sram_addr = 8'h77;
        step();
        chk("udf_wren", 64'(o_sram_wren), 64'(0));
        chk("udf_flag", 64'(o_udf_err), 64'(1));
        chk("udf_addrhold", 64'(o_sram_addr), 64'(8'h4A));
        idle();
        i_clear = 1'b1;
        step();
        idle();
        chk("udfclr_flag",  64'(o_udf_err), 64'(0));
        chk("udfclr_count", 64'(o_count), 64'(0));
        chk("udfclr_empty", 64'(o_empty), 64'(1));

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            i_push = 1'b1; i_push_data = fw[i];
            step();
        end
        idle();
        i_cnt_en = 1'b1; i_mask = 2'b01; i_sram_addr = 8'h33;
        step();
        idle();
        chk("arst_pre_count", 64'(o_count), 64'(3));
        chk("arst_pre_wren",  64'(o_sram_wren), 64'(1));
        #2 i_rst = 1'b1;
        #1;
        chk("arst_empty", 64'(o_empty), 64'(1));
        chk("arst_count", 64'(o_count), 64'(0));
        chk("arst_wren",  64'(o_sram_wren), 64'(0));
        chk("arst_addr",  64'(o_sram_addr), 64'(0));
        chk("arst_udf",   64'(o_udf_err), 64'(0));
        #2 i_rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
